// File: rtl/yrv_irq_seq_pkg.sv
// Shared interrupt defines for the YRV core: exception cause codes and irq_bus bit positions.
package yrv_irq_seq_pkg;

    localparam logic [6:0] EC_NULL = 7'h00;
    localparam logic [6:0] EC_NMI  = 7'h00;
    localparam logic [6:0] EC_MSI  = 7'h03;
    localparam logic [6:0] EC_MTI  = 7'h07;
    localparam logic [6:0] EC_MEI  = 7'h0B;
    localparam logic [6:0] EC_LI0  = 7'h10;
    localparam logic [6:0] EC_LI1  = 7'h11;
    localparam logic [6:0] EC_LI2  = 7'h12;
    localparam logic [6:0] EC_LI3  = 7'h13;
    localparam logic [6:0] EC_LI4  = 7'h14;
    localparam logic [6:0] EC_LI5  = 7'h15;
    localparam logic [6:0] EC_LI6  = 7'h16;
    localparam logic [6:0] EC_LI7  = 7'h17;
    localparam logic [6:0] EC_LI8  = 7'h18;
    localparam logic [6:0] EC_LI9  = 7'h19;
    localparam logic [6:0] EC_LI10 = 7'h1A;
    localparam logic [6:0] EC_LI11 = 7'h1B;
    localparam logic [6:0] EC_LI12 = 7'h1C;
    localparam logic [6:0] EC_LI13 = 7'h1D;
    localparam logic [6:0] EC_LI14 = 7'h1E;
    localparam logic [6:0] EC_LI15 = 7'h1F;

    localparam int IRQ_SW  = 0;
    localparam int IRQ_TMR = 1;
    localparam int IRQ_EI  = 2;
    localparam int IRQ_LI  = 3;
    localparam int IRQ_NMI = 4;

endpackage

// File: rtl/yrv_irq_seq_if.sv
// Signals between the interrupt unit / pipeline (master) and the acknowledge sequencer (slave).
interface yrv_irq_seq_if;

    // Handshake: the sequencer raises trap_req with frozen trap_cause/trap_nmi; the pipeline
    // answers with trap_ack, which completes the transfer on any edge where trap_req is high
    // (including the first one). trap_ack while trap_req is low has no effect.
    logic [4:0] irq_bus;
    logic [6:0] mli_code;
    logic       inst_bnd;
    logic       wfi_state;
    logic       trap_ack;
    logic       mret_exec;
    logic       trap_req;
    logic [6:0] trap_cause;
    logic       trap_nmi;
    logic       iack_nmi;
    logic       mie_clr;
    logic       nmi_active;
    logic       wfi_wake;

    modport master (
        output irq_bus, mli_code, inst_bnd, wfi_state, trap_ack, mret_exec,
        input  trap_req, trap_cause, trap_nmi, iack_nmi, mie_clr, nmi_active, wfi_wake
    );

    modport slave (
        input  irq_bus, mli_code, inst_bnd, wfi_state, trap_ack, mret_exec,
        output trap_req, trap_cause, trap_nmi, iack_nmi, mie_clr, nmi_active, wfi_wake
    );

endinterface

// File: rtl/yrv_irq_pri.sv
// Fixed-priority interrupt selector: nmi > ei > sw > tmr > li, producing the trap cause.
module yrv_irq_pri
    import yrv_irq_seq_pkg::*;
(
    input  logic [4:0] eligible,
    input  logic [6:0] mli_code,
    output logic [6:0] cause,
    output logic       is_nmi,
    output logic       any
);

    always_comb begin
        cause  = EC_NULL;
        is_nmi = 1'b0;
        any    = |eligible;
        if (eligible[IRQ_NMI]) begin
            cause  = EC_NMI;
            is_nmi = 1'b1;
        end else if (eligible[IRQ_EI]) begin
            cause = EC_MEI;
        end else if (eligible[IRQ_SW]) begin
            cause = EC_MSI;
        end else if (eligible[IRQ_TMR]) begin
            cause = EC_MTI;
        end else if (eligible[IRQ_LI]) begin
            cause = mli_code;
        end
    end

endmodule

// File: rtl/yrv_irq_seq.sv
// Interrupt acknowledge sequencer: samples requests at boundaries/WFI, holds one frozen trap
// request through the pipeline handshake, then blanks one cycle so irq_bus can settle.
module yrv_irq_seq
    import yrv_irq_seq_pkg::*;
(
    input  logic             clk,
    input  logic             resetb,
    yrv_irq_seq_if.slave     bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] eligible;
    logic [6:0] pri_cause;
    logic       pri_nmi;
    logic       pri_any;
    logic       take;

    // A running NMI handler masks further NMIs until mret.
    assign eligible = bus.irq_bus & ~{bus.nmi_active, 4'b0000};
    assign take     = (bus.inst_bnd | bus.wfi_state) & pri_any;
    assign dbg_state = state;

    yrv_irq_pri u_pri (
        .eligible (eligible),
        .mli_code (bus.mli_code),
        .cause    (pri_cause),
        .is_nmi   (pri_nmi),
        .any      (pri_any)
    );

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state          <= ST_IDLE;
            bus.trap_req   <= 1'b0;
            bus.trap_cause <= EC_NULL;
            bus.trap_nmi   <= 1'b0;
            bus.iack_nmi   <= 1'b0;
            bus.mie_clr    <= 1'b0;
            bus.nmi_active <= 1'b0;
            bus.wfi_wake   <= 1'b0;
        end else begin
            bus.iack_nmi <= 1'b0;
            bus.mie_clr  <= 1'b0;
            bus.wfi_wake <= 1'b0;
            if (bus.mret_exec) begin
                bus.nmi_active <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        state          <= ST_REQ;
                        bus.trap_req   <= 1'b1;
                        bus.trap_cause <= pri_cause;
                        bus.trap_nmi   <= pri_nmi;
                        bus.wfi_wake   <= bus.wfi_state;
                    end
                end
                ST_REQ: begin
                    if (bus.trap_ack) begin
                        state        <= ST_BLANK;
                        bus.trap_req <= 1'b0;
                        bus.mie_clr  <= 1'b1;
                        bus.iack_nmi <= bus.trap_nmi;
                        // Placed after the mret clear so a coincident NMI take wins.
                        if (bus.trap_nmi) begin
                            bus.nmi_active <= 1'b1;
                        end
                    end
                end
                ST_BLANK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yrv_irq_seq.sv
// Bench for yrv_irq_seq: directed scenarios then random traffic against a transaction-level model.
module tb_yrv_irq_seq;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [1:0] dbg_state;

  yrv_irq_seq_if bus ();

  yrv_irq_seq dut (
    .clk       (clk),
    .resetb    (resetb),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // {nmi, cause} of every trap the model decides to take
  logic [7:0] exp_q[$];

  // model state, written only at the active edge
  bit         m_pending = 0;
  bit         m_blank = 0;
  bit         e_req = 0;
  logic [6:0] e_cause = 7'h00;
  bit         e_nmi = 0;
  bit         e_iack = 0;
  bit         e_mie = 0;
  bit         e_nmi_act = 0;
  bit         e_wake = 0;

  bit         mon_en = 0;
  bit         prev_req = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Highest-priority pending source; order nmi, ei, sw, tmr, li.
  function automatic logic [7:0] pick(input logic [4:0] elig, input logic [6:0] mli);
    int order[5] = '{4, 2, 0, 1, 3};
    logic [6:0] codes[5];
    codes[0] = 7'h00; codes[1] = 7'h0B; codes[2] = 7'h03; codes[3] = 7'h07; codes[4] = mli;
    for (int k = 0; k < 5; k++) begin
      if (elig[order[k]]) return {(k == 0) ? 1'b1 : 1'b0, codes[k]};
    end
    return 8'h00;
  endfunction

  // Advances the model by one edge using the inputs the DUT samples at that edge.
  task automatic model_edge();
    logic [4:0] elig;
    logic [7:0] tr;
    bit         old_nmi_act;
    if (!resetb) begin
      m_pending = 0; m_blank = 0; e_req = 0; e_cause = 7'h00; e_nmi = 0;
      e_iack = 0; e_mie = 0; e_nmi_act = 0; e_wake = 0;
      exp_q.delete();
      return;
    end
    old_nmi_act = e_nmi_act;
    e_iack = 0; e_mie = 0; e_wake = 0;
    if (bus.mret_exec) e_nmi_act = 0;
    if (m_pending) begin
      if (bus.trap_ack) begin
        m_pending = 0; m_blank = 1; e_req = 0; e_mie = 1; e_iack = e_nmi;
        if (e_nmi) e_nmi_act = 1;
      end
    end else if (m_blank) begin
      m_blank = 0;
    end else begin
      elig = bus.irq_bus;
      if (old_nmi_act) elig[4] = 1'b0;
      if ((bus.inst_bnd || bus.wfi_state) && elig != 5'b0) begin
        tr = pick(elig, bus.mli_code);
        m_pending = 1; e_req = 1; e_nmi = tr[7]; e_cause = tr[6:0]; e_wake = bus.wfi_state;
        exp_q.push_back(tr);
      end
    end
  endtask

  task automatic cy(input logic [4:0] irq, input bit bnd, input bit wfi, input bit ack,
                    input bit mret, input int n = 1);
    for (int i = 0; i < n; i++) begin
      bus.irq_bus = irq; bus.inst_bnd = bnd; bus.wfi_state = wfi;
      bus.trap_ack = ack; bus.mret_exec = mret;
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  // Monitor: per-cycle output checks plus scoreboard pop when a new request appears.
  always @(negedge clk) begin
    logic [7:0] tr;
    if (mon_en) begin
      chk("trap_req", {7'b0, bus.trap_req}, {7'b0, e_req});
      chk("trap_cause", {1'b0, bus.trap_cause}, {1'b0, e_cause});
      chk("trap_nmi", {7'b0, bus.trap_nmi}, {7'b0, e_nmi});
      chk("iack_nmi", {7'b0, bus.iack_nmi}, {7'b0, e_iack});
      chk("mie_clr", {7'b0, bus.mie_clr}, {7'b0, e_mie});
      chk("nmi_active", {7'b0, bus.nmi_active}, {7'b0, e_nmi_act});
      chk("wfi_wake", {7'b0, bus.wfi_wake}, {7'b0, e_wake});
      if (bus.trap_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected_trap actual=%0h expected=none", bus.trap_cause);
        end else begin
          tr = exp_q.pop_front();
          chk("sb_trap", {bus.trap_nmi, bus.trap_cause}, tr);
        end
      end
      prev_req = bus.trap_req;
    end
  end

  initial begin
    bus.mli_code = 7'h12;
    resetb = 1'b0;
    cy(5'b0, 0, 0, 0, 0);
    mon_en = 1;
    cy(5'b0, 0, 0, 0, 0);
    resetb = 1'b1;
    cy(5'b0, 0, 0, 0, 0, 2);

    // reset while a request is outstanding
    cy(5'b00100, 1, 0, 0, 0, 2);
    resetb = 1'b0;
    cy(5'b00100, 0, 0, 1, 0);
    resetb = 1'b1;
    cy(5'b0, 0, 0, 0, 0, 2);

    // priority: ei first, then sw
    cy(5'b01111, 1, 0, 0, 0);
    cy(5'b01111, 0, 0, 1, 0);
    cy(5'b01011, 1, 0, 0, 0, 2);
    cy(5'b01011, 0, 0, 1, 0);
    cy(5'b0, 0, 0, 0, 0, 3);

    // NMI handshake, nesting blocked until mret
    cy(5'b10000, 1, 0, 0, 0);
    cy(5'b10000, 0, 0, 1, 0);
    cy(5'b10000, 1, 0, 0, 0, 4);
    cy(5'b10000, 0, 0, 0, 1);
    cy(5'b10000, 1, 0, 0, 0);
    cy(5'b10000, 0, 0, 1, 1);
    cy(5'b0, 0, 0, 0, 1);
    cy(5'b0, 0, 0, 0, 0, 2);

    // frozen request across an arriving NMI
    cy(5'b00010, 1, 0, 0, 0);
    cy(5'b10000, 1, 0, 0, 0, 2);
    cy(5'b10000, 1, 0, 1, 0);
    cy(5'b10000, 1, 0, 0, 0, 3);
    cy(5'b0, 0, 0, 1, 0);
    cy(5'b0, 0, 0, 0, 1);
    cy(5'b0, 0, 0, 0, 0, 2);

    // wake from WFI
    cy(5'b00010, 0, 1, 0, 0);
    cy(5'b00010, 0, 0, 1, 0);
    cy(5'b0, 0, 0, 0, 0, 3);

    // ack held high: one request per 3 cycles
    cy(5'b00001, 1, 0, 1, 0, 12);
    cy(5'b0, 0, 0, 0, 0, 3);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      bus.mli_code = 7'($urandom_range(16, 31));
      resetb = ($urandom_range(0, 99) != 0);
      cy(5'($urandom & $urandom), bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
         bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end
    resetb = 1'b1;
    cy(5'b0, 0, 0, 1, 1, 4);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/yrv_irq_seq.md
# yrv_irq_seq

Interrupt acknowledge sequencer for the YRV core: the consumer end of the interrupt unit's `irq_bus`/`mli_code` outputs and the producer of its `iack_nmi` input. It samples pending requests at instruction boundaries or in WFI, and arbitrates by fixed priority. It presents one frozen trap request with a cause code to the pipeline, completes a request/acknowledge handshake, and issues the NMI acknowledge and master-enable-clear pulses. It also tracks NMI nesting until `mret`.

## Interface
Parameters: none.
- clk  in  1  main cpu clock
- resetb  in  1  master reset; synchronous, active-low
- irq_bus  in  5  request lines {nmi, li, ei, tmr, sw}, bit 4 = nmi
- mli_code  in  7  encoded highest-priority local interrupt cause
- inst_bnd  in  1  pipeline at an instruction boundary; interrupt may be taken this cycle
- wfi_state  in  1  core waiting for interrupt; treated as a boundary
- trap_ack  in  1  pipeline has accepted `trap_req`, with vector fetch started
- mret_exec  in  1  `mret` retiring this cycle
- trap_req  out  1  trap request to pipeline
- trap_cause  out  7  cause of the pending or last-taken trap
- trap_nmi  out  1  pending or last-taken trap is NMI (NMI vector select)
- iack_nmi  out  1  one-cycle NMI acknowledge to interrupt unit
- mie_clr  out  1  one-cycle pulse: clear mie, save mpie
- nmi_active  out  1  NMI handler in progress
- wfi_wake  out  1  one-cycle pulse: leave WFI

## Operation
- States: IDLE, REQ, BLANK. Reset state IDLE.
- Take condition, evaluated in IDLE: `(inst_bnd | wfi_state) & (|eligible)`.
  - eligible = irq_bus with bit 4 masked while nmi_active.
- Priority: nmi > ei > sw > tmr > li.
- Cause codes: EC_NMI=7'h00, EC_MSI=7'h03, EC_MTI=7'h07, EC_MEI=7'h0B. For li, `trap_cause` = mli_code.
- IDLE -> REQ on the take condition:
  - latch cause into trap_cause;
  - set trap_nmi for nmi, else clear it;
  - raise trap_req;
  - pulse wfi_wake if wfi_state.
- REQ: trap_req, trap_cause and trap_nmi are held frozen regardless of irq_bus changes, including a new NMI or a withdrawn maskable request.
- REQ -> BLANK on trap_ack:
  - drop trap_req;
  - pulse mie_clr;
  - pulse iack_nmi if trap_nmi, and set nmi_active.
- BLANK -> IDLE unconditionally after one cycle. This lets irq_bus reflect the cleared mie and the cleared NMI pending state before resampling.
- nmi_active clears on mret_exec. If the NMI take (trap_ack with trap_nmi) and mret_exec occur in the same cycle, set wins.
- trap_ack outside REQ is ignored. mret_exec in any state only affects nmi_active.
- trap_cause and trap_nmi keep their last value in IDLE and BLANK.

## Timing
- Reset values: trap_req=0, trap_cause=7'h00, trap_nmi=0, iack_nmi=0, mie_clr=0, nmi_active=0, wfi_wake=0.
- Reset is synchronous; any state returns to IDLE at the next edge with resetb low, including mid-REQ.
- All outputs are registered.
- Take condition true at edge N: trap_req=1 and cause valid after N; wfi_wake high for cycle N+1 only.
- trap_ack=1 at edge M:
  - trap_req=0, mie_clr=1, iack_nmi (NMI only) =1 during cycle M+1;
  - pulses clear at M+2;
  - state is BLANK during M+1 and IDLE during M+2;
  - earliest next trap_req is at cycle M+3.
- trap_ack in the same cycle trap_req first rises is legal and completes the handshake.
- Minimum interrupt-to-interrupt spacing: 3 cycles.

## Structure
- Shared defines header: EC_NMI, EC_MSI, EC_MTI, EC_MEI, placed beside the existing EC_LI0..EC_LI15 and EC_NULL. Also holds the irq_bus bit index constants IRQ_SW=0, IRQ_TMR=1, IRQ_EI=2, IRQ_LI=3, IRQ_NMI=4.
- State encodings stay local to the block.
- One combinational sub-module, `yrv_irq_pri`: eligible bits and mli_code in, {cause, is_nmi, any} out.
- The FSM and pulse registers stay in the top.

## Test plan
- Reset mid-REQ: irq_bus=5'b00100, inst_bnd=1, then resetb=0 while in REQ. Required: next edge all outputs 0, IDLE; no iack_nmi.
- Priority: irq_bus=5'b01111, mli_code=7'h12, inst_bnd=1. Required: trap_cause=7'h0B, trap_nmi=0. After ack and BLANK, with irq_bus=5'b01011, the next trap has cause 7'h03.
- NMI handshake: irq_bus=5'b10000 at boundary. Required: trap_nmi=1, cause 7'h00; trap_ack gives iack_nmi=1 and mie_clr=1 for exactly one cycle, and nmi_active=1. A second NMI before mret_exec is not taken; after mret_exec it is taken.
- Frozen request: in REQ with cause 7'h07, change irq_bus to 5'b10000. Required: trap_cause stays 7'h07 until trap_ack; NMI is taken at M+3.
- WFI wake: wfi_state=1, inst_bnd=0, irq_bus=5'b00010. Required: wfi_wake pulses one cycle, trap_req=1, cause 7'h07.
- Same-cycle ack: trap_ack held at 1 continuously with irq_bus=5'b00001 and inst_bnd=1. Required: trap_req high for one cycle per 3-cycle period, cause 7'h03.
